// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: decoder bundle, memory handshakes and datapath strobes for the multi-cycle sequencer
interface multicycle_ctrl_fsm_if #(parameter int CNT_W = 32);
    logic             run, imem_ready, dmem_ready;
    logic             dec_reg_write, dec_mem_read, dec_mem_write, dec_branch;
    logic             dec_jump, dec_is_float, dec_mfc1, dec_mtc1;
    logic [1:0]       dec_jump_src;
    logic             branch_cond;
    logic [2:0]       state;
    logic             imem_req, ir_we, dmem_req, dmem_we, gpr_we, fpr_we, pc_we;
    logic [1:0]       pc_src;
    logic             busy, fault;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, imem_ready, dmem_ready, dec_reg_write, dec_mem_read, dec_mem_write,
               dec_branch, dec_jump, dec_is_float, dec_mfc1, dec_mtc1, dec_jump_src, branch_cond,
        output state, imem_req, ir_we, dmem_req, dmem_we, gpr_we, fpr_we, pc_we, pc_src,
               busy, fault, instr_count
    );
    modport slave (
        output run, imem_ready, dmem_ready, dec_reg_write, dec_mem_read, dec_mem_write,
               dec_branch, dec_jump, dec_is_float, dec_mfc1, dec_mtc1, dec_jump_src, branch_cond,
        input  state, imem_req, ir_we, dmem_req, dmem_we, gpr_we, fpr_we, pc_we, pc_src,
               busy, fault, instr_count
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout, sticky fault and retire counter
module multicycle_ctrl_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input logic clk,
    input logic rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5, FAULT = 3'd7
    } state_t;

    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t           st, after;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       pc_src;
    logic             mem_op, illegal, exec_retire, retire, ready_now, tmo;

    always_comb begin
        mem_op      = bus.dec_mem_read | bus.dec_mem_write;
        illegal     = bus.dec_mem_read & bus.dec_mem_write;
        exec_retire = !illegal && (bus.dec_jump ? !bus.dec_reg_write
                    : bus.dec_branch || !(mem_op || bus.dec_reg_write || bus.dec_mtc1));
        retire      = (st == EXEC && exec_retire) || (st == MEM && bus.dmem_ready && !bus.dec_mem_read) || st == WB;
        ready_now   = st == FETCH ? bus.imem_ready : bus.dmem_ready;
        // the cycle that would be the TIMEOUT-th wait is the one that faults, unless ready shows up in it
        tmo         = TIMEOUT != 0 && wait_cnt == LIMIT;
        after       = bus.run ? FETCH : IDLE;
    end

    assign bus.state       = st;
    assign bus.imem_req    = st == FETCH;
    assign bus.ir_we       = st == FETCH && bus.imem_ready;
    assign bus.dmem_req    = st == MEM;
    assign bus.dmem_we     = st == MEM && bus.dec_mem_write;
    assign bus.gpr_we      = st == WB && bus.dec_reg_write && (!bus.dec_is_float || bus.dec_mfc1);
    assign bus.fpr_we      = st == WB && ((bus.dec_is_float && bus.dec_reg_write && !bus.dec_mfc1) || bus.dec_mtc1);
    assign bus.pc_we       = retire;
    assign bus.pc_src      = pc_src;
    assign bus.busy        = st != IDLE && st != FAULT;
    assign bus.fault       = st == FAULT;
    assign bus.instr_count = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            pc_src   <= '0;
            cnt      <= '0;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            if ((st == FETCH || st == MEM) && !ready_now && !tmo) wait_cnt <= wait_cnt + 1'b1;
            if (retire) cnt <= cnt + 1'b1;
            case (st)
                IDLE:   st <= after;
                FETCH:  st <= bus.imem_ready ? DECODE : tmo ? FAULT : FETCH;
                DECODE: st <= EXEC;
                EXEC: begin
                    if (!illegal)
                        pc_src <= bus.dec_jump ? (bus.dec_jump_src == 2'b10 ? 2'b11 : 2'b10)
                                               : {1'b0, bus.dec_branch & bus.branch_cond};
                    st <= illegal ? FAULT : exec_retire ? after : (mem_op && !bus.dec_jump) ? MEM : WB;
                end
                MEM:     st <= bus.dmem_ready ? (bus.dec_mem_read ? WB : after) : tmo ? FAULT : MEM;
                WB:      st <= after;
                default: st <= FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed per-cycle checks of state, strobes, pc_src and retire count
module tb_multicycle_ctrl_fsm;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.CNT_W(4)) bus();
    multicycle_ctrl_fsm #(.TIMEOUT(4), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // strobe vector order: imem_req ir_we dmem_req dmem_we gpr_we fpr_we pc_we busy fault
    localparam logic [8:0] O_0   = 9'b000000000;
    localparam logic [8:0] O_F   = 9'b110000010;
    localparam logic [8:0] O_FW  = 9'b100000010;
    localparam logic [8:0] O_B   = 9'b000000010;
    localparam logic [8:0] O_M   = 9'b001000010;
    localparam logic [8:0] O_SW  = 9'b001100110;
    localparam logic [8:0] O_RET = 9'b000000110;
    localparam logic [8:0] O_WBG = 9'b000010110;
    localparam logic [8:0] O_WBF = 9'b000001110;
    localparam logic [8:0] O_FLT = 9'b000000001;

    // bundle order: reg_write mem_read mem_write branch jump is_float mfc1 mtc1
    localparam logic [7:0] ADD  = 8'b1000_0000;
    localparam logic [7:0] LW   = 8'b1100_0000;
    localparam logic [7:0] SW   = 8'b0010_0000;
    localparam logic [7:0] BEQ  = 8'b0001_0000;
    localparam logic [7:0] JMP  = 8'b0000_1000;
    localparam logic [7:0] JAL  = 8'b1000_1000;
    localparam logic [7:0] FADD = 8'b1000_0100;
    localparam logic [7:0] MFC1 = 8'b1000_0110;
    localparam logic [7:0] MTC1 = 8'b0000_0001;
    localparam logic [7:0] NOP  = 8'b0000_0000;
    localparam logic [7:0] ILL  = 8'b0110_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // check the current cycle, then move to 1 time unit after the next rising edge
    task automatic step(input string tag, input logic [2:0] es, input logic [8:0] eo);
        #1;
        chk({tag, "_state"}, 32'(bus.state), 32'(es));
        chk({tag, "_out"}, 32'({bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.gpr_we,
                                bus.fpr_we, bus.pc_we, bus.busy, bus.fault}), 32'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [7:0] b, input logic [1:0] js);
        {bus.dec_reg_write, bus.dec_mem_read, bus.dec_mem_write, bus.dec_branch,
         bus.dec_jump, bus.dec_is_float, bus.dec_mfc1, bus.dec_mtc1} = b;
        bus.dec_jump_src = js;
    endtask

    task automatic fde(input string tag, input logic [8:0] exec_out);
        step({tag, "_f"}, 3'd1, O_F);
        step({tag, "_d"}, 3'd2, O_B);
        step({tag, "_e"}, 3'd3, exec_out);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        bus.branch_cond = 1'b0;
        dec(NOP, 2'b00);
        @(posedge clk);
        #1;
        chk("rst_cnt", 32'(bus.instr_count), 0);
        chk("rst_pcsrc", 32'(bus.pc_src), 0);
        rst_n = 1'b1;
        step("idle", 3'd0, O_0);
        bus.run = 1'b1;
        step("idle_run", 3'd0, O_0);

        dec(ADD, 2'b00);
        fde("add", O_B);
        step("add_wb", 3'd5, O_WBG);
        chk("add_pcsrc", 32'(bus.pc_src), 0);
        chk("add_cnt", 32'(bus.instr_count), 1);

        // lw with three wait cycles; ready lands on the timeout cycle and must win
        dec(LW, 2'b00);
        bus.dmem_ready = 1'b0;
        fde("lw", O_B);
        step("lw_m1", 3'd4, O_M);
        step("lw_m2", 3'd4, O_M);
        step("lw_m3", 3'd4, O_M);
        bus.dmem_ready = 1'b1;
        step("lw_m4", 3'd4, O_M);
        step("lw_wb", 3'd5, O_WBG);
        chk("lw_cnt", 32'(bus.instr_count), 2);

        dec(SW, 2'b00);
        fde("sw", O_B);
        step("sw_m", 3'd4, O_SW);
        chk("sw_cnt", 32'(bus.instr_count), 3);

        dec(BEQ, 2'b00);
        bus.branch_cond = 1'b1;
        fde("beq_t", O_RET);
        chk("beq_t_pcsrc", 32'(bus.pc_src), 1);
        chk("beq_t_cnt", 32'(bus.instr_count), 4);
        bus.branch_cond = 1'b0;
        fde("beq_n", O_RET);
        chk("beq_n_pcsrc", 32'(bus.pc_src), 0);
        chk("beq_n_cnt", 32'(bus.instr_count), 5);

        dec(JMP, 2'b10);
        fde("jr", O_RET);
        chk("jr_pcsrc", 32'(bus.pc_src), 3);
        chk("jr_cnt", 32'(bus.instr_count), 6);

        dec(JAL, 2'b00);
        fde("jal", O_B);
        step("jal_wb", 3'd5, O_WBG);
        chk("jal_pcsrc", 32'(bus.pc_src), 2);
        chk("jal_cnt", 32'(bus.instr_count), 7);

        dec(FADD, 2'b00);
        fde("fadd", O_B);
        step("fadd_wb", 3'd5, O_WBF);
        chk("fadd_pcsrc", 32'(bus.pc_src), 0);
        dec(MTC1, 2'b00);
        fde("mtc1", O_B);
        step("mtc1_wb", 3'd5, O_WBF);
        dec(MFC1, 2'b00);
        fde("mfc1", O_B);
        step("mfc1_wb", 3'd5, O_WBG);
        chk("mfc1_cnt", 32'(bus.instr_count), 10);

        // dropping run mid-instruction still retires it, then parks in IDLE
        dec(NOP, 2'b00);
        step("nop_f", 3'd1, O_F);
        bus.run = 1'b0;
        step("nop_d", 3'd2, O_B);
        step("nop_e", 3'd3, O_RET);
        step("idle_hold", 3'd0, O_0);
        chk("stop_cnt", 32'(bus.instr_count), 11);
        bus.run = 1'b1;
        step("idle_go", 3'd0, O_0);

        for (int i = 0; i < 5; i++) begin
            fde("nop_loop", O_RET);
            chk("wrap_cnt", 32'(bus.instr_count), (12 + i) & 15);
        end

        dec(ILL, 2'b00);
        fde("ill", O_B);
        step("ill_flt", 3'd7, O_FLT);
        bus.run = 1'b0;
        step("ill_hold", 3'd7, O_FLT);
        chk("ill_cnt", 32'(bus.instr_count), 0);
        chk("ill_pcsrc", 32'(bus.pc_src), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_flt_async", 32'(bus.state), 0);
        rst_n = 1'b1;
        bus.run = 1'b1;

        dec(ADD, 2'b00);
        step("idle3", 3'd0, O_0);
        fde("add2", O_B);
        step("add2_wb", 3'd5, O_WBG);
        chk("add2_cnt", 32'(bus.instr_count), 1);
        dec(LW, 2'b00);
        bus.dmem_ready = 1'b0;
        fde("lw2", O_B);
        step("lw2_m", 3'd4, O_M);
        bus.imem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_state", 32'(bus.state), 0);
        chk("rst_mem_cnt", 32'(bus.instr_count), 0);
        chk("rst_mem_dmem_req", 32'(bus.dmem_req), 0);
        rst_n = 1'b1;

        step("idle4", 3'd0, O_0);
        for (int i = 0; i < 4; i++) step("to_fetch", 3'd1, O_FW);
        step("to_flt", 3'd7, O_FLT);
        bus.imem_ready = 1'b1;
        step("to_hold", 3'd7, O_FLT);
        chk("to_cnt", 32'(bus.instr_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the mini-MIPS core. It consumes the control bundle from the instruction decoder and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- It drives PC, IR, memory-request and register-file write strobes, and counts retired instructions.
- It sits between the decoder and the datapath muxes and enables.
- It raises a sticky fault on a memory timeout or an illegal control combination.

Parameters:
- TIMEOUT, 16: maximum consecutive cycles with ready low in FETCH or MEM before FAULT; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; allows the FSM to leave IDLE and to continue after retire
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_is_float, dec_mfc1, dec_mtc1  in  1 each  decoder control bundle
- dec_jump_src  in  2  decoder jump source; 2'b10 means jr
- branch_cond  in  1  branch comparison result from the ALU, valid in EXEC
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7
- imem_req  out  1  instruction fetch request
- ir_we  out  1  IR load strobe
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write
- gpr_we  out  1  integer register file write
- fpr_we  out  1  FP register file write
- pc_we  out  1  PC update strobe
- pc_src  out  2  00 = pc+4, 01 = branch target, 10 = jump target, 11 = register (jr)
- busy  out  1  state is neither IDLE nor FAULT
- fault  out  1  sticky error
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n low, at any time including mid-instruction):
  - state = IDLE; pc_src = 00; instr_count = 0; wait counter = 0.
  - All strobes 0; busy = 0; fault = 0.
- Output decoding:
  - Strobes are combinational from the registered state plus ready inputs.
  - pc_src is a register written only in EXEC.
- IDLE: run = 1 -> FETCH; otherwise stay in IDLE.
- FETCH:
  - imem_req = 1.
  - imem_ready = 1 -> ir_we = 1 in that same cycle, next state DECODE.
  - imem_ready = 0 -> wait counter increments.
- DECODE: one cycle, no strobes, -> EXEC.
- EXEC: classify the instruction in priority order; the first matching case wins.
  1. dec_mem_read & dec_mem_write both set -> FAULT.
  2. dec_jump:
     - pc_src = 11 if dec_jump_src = 10, else pc_src = 10.
     - dec_reg_write (jal) -> WB; otherwise retire.
  3. dec_branch: pc_src = branch_cond ? 01 : 00; retire.
  4. dec_mem_read | dec_mem_write: pc_src = 00; -> MEM.
  5. dec_reg_write | dec_mtc1: pc_src = 00; -> WB.
  6. Anything else (nop, FP compare): pc_src = 00; retire.
- MEM:
  - dmem_req = 1; dmem_we = dec_mem_write.
  - dmem_ready = 1 -> WB if dec_mem_read, else retire.
  - dmem_ready = 0 -> wait counter increments.
- WB (exactly one cycle):
  - gpr_we = dec_reg_write & (~dec_is_float | dec_mfc1).
  - fpr_we = (dec_is_float & dec_reg_write & ~dec_mfc1) | dec_mtc1.
  - Then retire.
- Retire, in the last cycle of every instruction:
  - pc_we = 1 for exactly one cycle.
  - instr_count increments; overflow wraps all-ones -> 0.
  - Next state: FETCH if run, else IDLE. Deasserting run never aborts an instruction in flight.
- Wait counter:
  - Cleared on entry to FETCH or MEM and on any ready.
  - TIMEOUT != 0 and count reaches TIMEOUT with ready still low -> FAULT at that edge.
  - Ready arriving in the same cycle as the timeout wins; the access completes normally.
- FAULT:
  - All strobes 0; fault = 1; busy = 0.
  - Exit only via rst_n.
- The decoder bundle must be held stable by the datapath from DECODE through retire; the FSM does not latch it.
- Zero-wait latencies, counted from FETCH entry to the retire cycle inclusive:
  - 3 cycles: branch, j, jr, nop.
  - 4 cycles: R-type, sw, jal.
  - 5 cycles: lw.

Test Plan:
- Zero-wait memory, run = 1, add bundle (reg_write = 1) -> states 1, 2, 3, 5; gpr_we pulses in cycle 4; pc_we = 1 with pc_src = 00; instr_count = 1.
- lw with dmem_ready delayed 3 cycles -> MEM held 4 cycles with dmem_req = 1, dmem_we = 0; WB gpr_we = 1; 8 cycles total.
- beq with branch_cond = 1, then again with 0 -> first retire pc_src = 01, second retire pc_src = 00; each 3 cycles; count = 2.
- jr (jump, jump_src = 10) gives pc_src = 11 with no WB; jal gives pc_src = 10, gpr_we = 1 in WB, 4 cycles.
- TIMEOUT = 4, imem_ready stuck low -> FAULT after FETCH + 4 cycles; fault = 1, busy = 0; held until rst_n; rst_n low mid-MEM returns to IDLE with count = 0.
- mem_read = mem_write = 1 -> FAULT from EXEC; pre-load instr_count = all-ones via retires (CNT_W = 4) -> wraps to 0.
